// File: rtl/product_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// product_accumulator_pkg
// Shared constants and types for the product accumulator slice.
//   PROD_W        : width of the signed product delivered by the multiplier
//   ACC_W_DEFAULT : default accumulator / result width (legal 64..128)
//   LEN_W_DEFAULT : default width of the term-count field
//   state_e       : accumulator control FSM states
// -----------------------------------------------------------------------------
package product_accumulator_pkg;

  localparam int PROD_W        = 64;
  localparam int ACC_W_DEFAULT = 72;
  localparam int LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage : product_accumulator_pkg

// File: rtl/product_accumulator_if.sv
// -----------------------------------------------------------------------------
// product_accumulator_if
// Groups the request, product-stream and result handshakes of the product
// accumulator.
//   start/len           : run request and number of terms
//   product/in_valid/in_ready : signed product stream (valid/ready)
//   result/out_valid/out_ready: signed sum handshake, held until taken
//   ovf                 : sum left the ACC_W range in the current/last run
//   busy                : accumulator is not idle
// Modports:
//   master : the producer/consumer around the accumulator
//   slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) ();

  logic                     start;
  logic [LEN_W-1:0]         len;
  logic signed [PROD_W-1:0] product;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  result;
  logic                     out_valid;
  logic                     out_ready;
  logic                     ovf;
  logic                     busy;

  modport master (
    output start, len, product, in_valid, out_ready,
    input  in_ready, result, out_valid, ovf, busy
  );

  modport slave (
    input  start, len, product, in_valid, out_ready,
    output in_ready, result, out_valid, ovf, busy
  );

endinterface : product_accumulator_if

// File: rtl/product_accumulator_acc_adder.sv
// -----------------------------------------------------------------------------
// acc_adder
// Combinational ACC_W-bit signed add of the running accumulator and a
// sign-extended 64-bit product, with directional overflow detection.
// Optional feature macro: PRODUCT_ACCUMULATOR_SATURATE_EN
//   defined   : an overflowing add clamps to the most positive / most negative
//               ACC_W value; sat_pos/sat_neg keep the sum pinned at that rail
//   undefined : the sum wraps modulo 2^ACC_W
// Ports:
//   sat_pos, sat_neg : (saturating build only) sticky clamp direction
//   acc              : current accumulator value
//   product          : signed product to add
//   sum              : next accumulator value
//   ovf_pos, ovf_neg : this add overflowed above max / below min
// -----------------------------------------------------------------------------
module acc_adder
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  input  logic                     sat_pos,
  input  logic                     sat_neg,
`endif
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] product,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf_pos,
  output logic                     ovf_neg
);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  // Positive rail wins; both flags cannot be set together because a
  // positive overflow needs a non-negative accumulator and vice versa.
  function automatic logic signed [ACC_W-1:0] clamp(
    input logic signed [ACC_W-1:0] v,
    input logic                    hi,
    input logic                    lo
  );
    logic signed [ACC_W-1:0] r;
    r = v;
    if (hi) begin
      r = MAX_V;
    end else if (lo) begin
      r = MIN_V;
    end
    return r;
  endfunction
`endif

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] raw;

  always_comb begin
    // Signed size cast sign-extends the product into the accumulator width.
    prod_ext = ACC_W'(product);
    raw      = acc + prod_ext;
    // Two's-complement overflow: operands share a sign the result lacks.
    ovf_pos  = ~acc[ACC_W-1] & ~prod_ext[ACC_W-1] &  raw[ACC_W-1];
    ovf_neg  =  acc[ACC_W-1] &  prod_ext[ACC_W-1] & ~raw[ACC_W-1];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    sum      = clamp(raw, ovf_pos | sat_pos, ovf_neg | sat_neg);
`else
    sum      = raw;
`endif
  end

endmodule : acc_adder

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
// Sums a run of len signed 64-bit products into an ACC_W-bit signed result.
// A run is requested with start in IDLE; products are accepted in ACCUM with
// a valid/ready handshake; the final sum is presented in DRAIN with
// out_valid held until out_ready. ovf flags a sum outside the ACC_W range and
// stays set until the next accepted start.
// Optional feature macro: PRODUCT_ACCUMULATOR_SATURATE_EN (clamp on overflow,
// otherwise wrap modulo 2^ACC_W).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : product_accumulator_if.slave (start, len, product, in_valid,
//         in_ready, result, out_valid, out_ready, ovf, busy)
// -----------------------------------------------------------------------------
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] result_q, result_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    ovf_q, ovf_d;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  logic                    sat_pos_q, sat_pos_d;
  logic                    sat_neg_q, sat_neg_d;
`endif

  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf_pos;
  logic                    add_ovf_neg;
  logic [LEN_W-1:0]        cnt_inc;

  acc_adder #(
    .ACC_W (ACC_W)
  ) u_acc_adder (
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    .sat_pos (sat_pos_q),
    .sat_neg (sat_neg_q),
`endif
    .acc     (acc_q),
    .product (bus.product),
    .sum     (sum),
    .ovf_pos (add_ovf_pos),
    .ovf_neg (add_ovf_neg)
  );

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    sat_pos_d = sat_pos_q;
    sat_neg_d = sat_neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d     = '0;
          ovf_d     = 1'b0;
          cnt_d     = '0;
          len_d     = bus.len;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
          sat_pos_d = 1'b0;
          sat_neg_d = 1'b0;
`endif
          if (bus.len == '0) begin
            // Empty run: present a zero sum without entering ACCUM.
            result_d = '0;
            state_d  = DRAIN;
          end else begin
            state_d  = ACCUM;
          end
        end
      end

      ACCUM: begin
        // Without in_valid the run simply waits; there is no timeout.
        if (bus.in_valid) begin
          acc_d     = sum;
          cnt_d     = cnt_inc;
          ovf_d     = ovf_q | add_ovf_pos | add_ovf_neg;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
          sat_pos_d = sat_pos_q | add_ovf_pos;
          sat_neg_d = sat_neg_q | add_ovf_neg;
`endif
          if (cnt_inc == len_q) begin
            // Capture the final sum on the last transfer so out_valid
            // and result appear together one cycle later.
            result_d = sum;
            state_d  = DRAIN;
          end
        end
      end

      DRAIN: begin
        // start is deliberately not looked at here.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      sat_pos_q <= 1'b0;
      sat_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      sat_pos_q <= sat_pos_d;
      sat_neg_q <= sat_neg_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;

endmodule : product_accumulator

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 72: accumulator/result width in bits; legal range 64..128.
REQ-002 SHALL have parameter LEN_W, default 8: width of the term-count field.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a new accumulation.
REQ-006 SHALL have port len, input, LEN_W: number of products to sum; sampled when start is accepted.
REQ-007 SHALL have port product, input, 64: signed two's-complement product from the multiplier output register.
REQ-008 SHALL have port in_valid, input, 1: product is valid this cycle.
REQ-009 SHALL have port in_ready, output, 1: block accepts product this cycle.
REQ-010 SHALL have port result, output, ACC_W: signed accumulated sum.
REQ-011 SHALL have port out_valid, output, 1: result is valid and held.
REQ-012 SHALL have port out_ready, input, 1: consumer takes result.
REQ-013 SHALL have port ovf, output, 1: overflow occurred during the current or most recent run.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and DRAIN.
REQ-016 In IDLE, start=1 SHALL clear acc, ovf and the term counter, latch len, and go to ACCUM, or to DRAIN directly when len=0 (result 0).
REQ-017 In IDLE and DRAIN, in_ready SHALL be 0; in ACCUM, in_ready SHALL be 1.
REQ-018 A product SHALL transfer when in_valid and in_ready are both high; acc SHALL become acc + sign-extended product on that edge.
REQ-019 After the transfer that brings the counter to len, the FSM SHALL enter DRAIN on that same edge; result SHALL equal the final sum.
REQ-020 DRAIN SHALL hold out_valid=1 with stable result and ovf until out_ready=1, then return to IDLE on that edge.
REQ-021 Latency: out_valid SHALL rise exactly one cycle after the last product transfer.
REQ-022 start SHALL be ignored outside IDLE, including when asserted together with out_ready in DRAIN.
REQ-023 Idle cycles (in_valid=0) in ACCUM SHALL leave acc and the counter unchanged, with no timeout.
REQ-024 ovf SHALL be set when the true signed sum leaves the ACC_W range; it SHALL stay set until the next accepted start.
REQ-025 result SHALL retain its last value in IDLE.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, acc=0, counter=0, latched len=0, result=0, ovf=0, in_ready=0, out_valid=0 and busy=0.
REQ-027 Reset mid-ACCUM or mid-DRAIN SHALL abandon the run; no result SHALL be produced after release.

Configuration
REQ-028 With macro PRODUCT_ACCUMULATOR_SATURATE_EN defined, an overflowing addition SHALL clamp acc to the most positive or most negative ACC_W value, and acc SHALL stay clamped in that direction for the rest of the run.
REQ-029 Without PRODUCT_ACCUMULATOR_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W; ovf SHALL still be flagged.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration typedef, the default ACC_W and LEN_W constants, and the product width constant of 64.
REQ-031 A single sub-module acc_adder SHALL hold the ACC_W signed add with overflow detection and the optional saturation.

Verification
REQ-032 len=3; products 5, -2, 7 on consecutive cycles -> out_valid one cycle after the third transfer, result=10, ovf=0.
REQ-033 len=0 start -> DRAIN next cycle, result=0, in_ready never high.
REQ-034 ACC_W=64, len=2; products 0x7FFF_FFFF_FFFF_FFFF and 1 -> ovf=1; result 0x7FFF_FFFF_FFFF_FFFF with SATURATE_EN, 0x8000_0000_0000_0000 without it.
REQ-035 len=4 with in_valid gaps and out_ready held low for 5 cycles -> correct sum, result stable while out_valid=1, start during DRAIN ignored.
REQ-036 rst asserted after 2 of 4 products -> all outputs 0 immediately; after release, a new len=1 run with product -9 gives result=-9.
